pmp_csr_file: RTL and testbench
===============================

PMP_CSR_FILE -- requirements
Module: pmp_csr_file

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: priv_mode  input  2  current privilege level (2'b11 = M).
REQ-004 SHALL have port: csr_we  input  1  CSR write request, sampled each cycle.
REQ-005 SHALL have port: csr_re  input  1  CSR read request, sampled each cycle.
REQ-006 SHALL have port: csr_addr  input  12  CSR address.
REQ-007 SHALL have port: csr_wdata  input  32  CSR write data.
REQ-008 SHALL have port: csr_rdata  output  32  registered read data.
REQ-009 SHALL have port: csr_rvalid  output  1  one-cycle read-data-valid pulse.
REQ-010 SHALL have port: csr_illegal  output  1  one-cycle illegal-access pulse.
REQ-011 SHALL have port: pmp_changed  output  1  one-cycle pulse when any stored PMP bit changed.
REQ-012 SHALL have ports: pmpcfg0_data..pmpcfg3_data  output  32 each  packed cfg registers (byte k of pmpcfgN = entry 4N+k).
REQ-013 SHALL have ports: pmpaddr0_data..pmpaddr15_data  output  32 each  address registers.

Function
REQ-014 SHALL decode pmpcfg0-3 at 0x3A0-0x3A3 and pmpaddr0-15 at 0x3B0-0x3BF; other addresses are unmapped.
REQ-015 SHALL treat a request (csr_we or csr_re) as illegal when csr_addr is unmapped or priv_mode != 2'b11.
REQ-016 SHALL, on an illegal request, pulse csr_illegal the next cycle, leave all registers unchanged, drive csr_rdata 0, and keep csr_rvalid 0.
REQ-017 SHALL, on a legal csr_re, drive csr_rdata with the addressed register value and pulse csr_rvalid for one cycle, both on the following cycle (latency 1).
REQ-018 SHALL, when csr_re and csr_we target the same address in the same cycle, return the pre-write value.
REQ-019 SHALL, on a legal csr_we, update the register at the rising edge so that the new value is visible on the *_data outputs the next cycle.
REQ-020 SHALL apply a pmpcfg write per byte: a byte whose current L bit (bit 7) is 1 stays unchanged; unlocked bytes take the write data.
REQ-021 SHALL force bits [6:5] of every written cfg byte to 0.
REQ-022 SHALL, for a written cfg byte with W=1 and R=0 (reserved combination), store both R and W as 0 while keeping X, A and L as written.
REQ-023 SHALL ignore a write to pmpaddr i when cfg i L=1.
REQ-024 SHALL ignore a write to pmpaddr i (i<15) when cfg i+1 has L=1 and A=2'b01 (TOR).
REQ-025 SHALL gate pmpaddr15 writes only by its own lock.
REQ-026 SHALL store all 32 bits of pmpaddr write data unchanged.
REQ-027 SHALL evaluate all lock checks against register values held before the write edge.
REQ-028 SHALL pulse pmp_changed the cycle after a write edge in which at least one stored bit changed; it SHALL stay 0 for fully blocked writes and same-value writes.
REQ-029 SHALL provide no path other than rst_n that clears an L bit.
REQ-030 SHALL produce outputs with no combinational path from any input.

Reset
REQ-031 SHALL, while rst_n=0, immediately (asynchronously) drive all pmpcfg*_data and pmpaddr*_data to 0.
REQ-032 SHALL, while rst_n=0, drive csr_rdata to 0 and csr_rvalid, csr_illegal and pmp_changed to 0.
REQ-033 SHALL discard any request in flight when rst_n asserts mid-operation, producing no pulse after release.
REQ-034 SHALL accept requests on the first rising edge after rst_n deasserts.

Verification
REQ-035 SHALL be verified by: M-mode write 0x3A0=0x0000_1F0F, then read 0x3A0 -> pmpcfg0_data=0x0000_1F0F, csr_rdata=0x0000_1F0F with csr_rvalid=1 one cycle after the read, pmp_changed pulses once.
REQ-036 SHALL be verified by: write 0x3A0=0x0000_0082 (entry0 L=1, W=1, R=0) -> stored 0x80; then write 0x3A0=0x0000_00FF -> byte0 stays 0x80, pmp_changed=0.
REQ-037 SHALL be verified by: cfg1=0x88 (L=1, TOR); write 0x3B0=0x1234_5678 -> pmpaddr0 unchanged; write 0x3B2=0x1234_5678 -> pmpaddr2=0x1234_5678.
REQ-038 SHALL be verified by: priv_mode=2'b00 write 0x3B3, and M-mode read 0x7C0 -> csr_illegal pulses each time, registers unchanged, csr_rvalid=0.
REQ-039 SHALL be verified by: same-cycle read+write of 0x3B5 (old 0xA, new 0xB) -> csr_rdata=0xA, pmpaddr5_data=0xB next cycle.
REQ-040 SHALL be verified by: asserting rst_n low mid-access after locking entries -> all outputs 0 immediately; after release, a write to 0x3A0 succeeds.

Source files
------------

// File: rtl/pmp_csr_file.sv
// PMP CSR file: 16 packed cfg bytes and 16 address registers behind an M-mode CSR port.
// Reads, write side effects and error pulses all appear one cycle after the request.
module pmp_csr_file #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        priv_mode,
    input  logic              csr_we,
    input  logic              csr_re,
    input  logic [11:0]       csr_addr,
    input  logic [DATA_W-1:0] csr_wdata,
    output logic [DATA_W-1:0] csr_rdata,
    output logic              csr_rvalid,
    output logic              csr_illegal,
    output logic              pmp_changed,
    output logic [DATA_W-1:0] pmpcfg0_data,
    output logic [DATA_W-1:0] pmpcfg1_data,
    output logic [DATA_W-1:0] pmpcfg2_data,
    output logic [DATA_W-1:0] pmpcfg3_data,
    output logic [DATA_W-1:0] pmpaddr0_data,
    output logic [DATA_W-1:0] pmpaddr1_data,
    output logic [DATA_W-1:0] pmpaddr2_data,
    output logic [DATA_W-1:0] pmpaddr3_data,
    output logic [DATA_W-1:0] pmpaddr4_data,
    output logic [DATA_W-1:0] pmpaddr5_data,
    output logic [DATA_W-1:0] pmpaddr6_data,
    output logic [DATA_W-1:0] pmpaddr7_data,
    output logic [DATA_W-1:0] pmpaddr8_data,
    output logic [DATA_W-1:0] pmpaddr9_data,
    output logic [DATA_W-1:0] pmpaddr10_data,
    output logic [DATA_W-1:0] pmpaddr11_data,
    output logic [DATA_W-1:0] pmpaddr12_data,
    output logic [DATA_W-1:0] pmpaddr13_data,
    output logic [DATA_W-1:0] pmpaddr14_data,
    output logic [DATA_W-1:0] pmpaddr15_data
);

    logic [15:0][7:0]        cfg_q, cfg_next;
    logic [15:0][DATA_W-1:0] addr_q, addr_next;
    logic                    is_cfg, is_addr, legal;
    logic [DATA_W-1:0]       rd_val;
    logic [3:0]              idx;

    // Bits [6:5] are hardwired zero; W=1,R=0 is reserved and collapses to no access.
    function automatic logic [7:0] cfg_sanitize(input logic [7:0] b);
        logic [7:0] s;
        s = b & 8'h9F;
        if (s[1:0] == 2'b10) s[1:0] = 2'b00;
        return s;
    endfunction

    function automatic logic addr_locked(input logic [3:0] i, input logic [15:0][7:0] cfg);
        logic [7:0] nxt;
        logic       lock;
        lock = cfg[i][7];
        nxt  = 8'h00;
        if (i != 4'd15) begin
            nxt  = cfg[i + 4'd1];
            lock = lock | (nxt[7] && nxt[4:3] == 2'b01);
        end
        return lock;
    endfunction

    assign is_cfg  = (csr_addr[11:2] == 10'b0011_1010_00);
    assign is_addr = (csr_addr[11:4] == 8'h3B);
    assign legal   = (is_cfg || is_addr) && (priv_mode == 2'b11);

    always_comb begin
        rd_val = addr_q[csr_addr[3:0]];
        if (is_cfg)
            rd_val = {cfg_q[{csr_addr[1:0], 2'd3}], cfg_q[{csr_addr[1:0], 2'd2}],
                      cfg_q[{csr_addr[1:0], 2'd1}], cfg_q[{csr_addr[1:0], 2'd0}]};
    end

    // Lock checks use pre-edge register values so one write cannot unlock itself.
    always_comb begin
        cfg_next  = cfg_q;
        addr_next = addr_q;
        idx       = 4'd0;
        if (csr_we && legal) begin
            if (is_cfg) begin
                for (int k = 0; k < 4; k++) begin
                    idx = {csr_addr[1:0], k[1:0]};
                    if (!cfg_q[idx][7]) cfg_next[idx] = cfg_sanitize(csr_wdata[8*k +: 8]);
                end
            end else if (!addr_locked(csr_addr[3:0], cfg_q)) begin
                addr_next[csr_addr[3:0]] = csr_wdata;
            end
        end
    end

    // Stage p1: register state, read data and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q       <= '0;
            addr_q      <= '0;
            csr_rdata   <= '0;
            csr_rvalid  <= 1'b0;
            csr_illegal <= 1'b0;
            pmp_changed <= 1'b0;
        end else begin
            cfg_q       <= cfg_next;
            addr_q      <= addr_next;
            csr_rdata   <= (csr_re && legal) ? rd_val : '0;
            csr_rvalid  <= csr_re && legal;
            csr_illegal <= (csr_we || csr_re) && !legal;
            pmp_changed <= (cfg_next != cfg_q) || (addr_next != addr_q);
        end
    end

    assign pmpcfg0_data   = cfg_q[3:0];
    assign pmpcfg1_data   = cfg_q[7:4];
    assign pmpcfg2_data   = cfg_q[11:8];
    assign pmpcfg3_data   = cfg_q[15:12];
    assign pmpaddr0_data  = addr_q[0];
    assign pmpaddr1_data  = addr_q[1];
    assign pmpaddr2_data  = addr_q[2];
    assign pmpaddr3_data  = addr_q[3];
    assign pmpaddr4_data  = addr_q[4];
    assign pmpaddr5_data  = addr_q[5];
    assign pmpaddr6_data  = addr_q[6];
    assign pmpaddr7_data  = addr_q[7];
    assign pmpaddr8_data  = addr_q[8];
    assign pmpaddr9_data  = addr_q[9];
    assign pmpaddr10_data = addr_q[10];
    assign pmpaddr11_data = addr_q[11];
    assign pmpaddr12_data = addr_q[12];
    assign pmpaddr13_data = addr_q[13];
    assign pmpaddr14_data = addr_q[14];
    assign pmpaddr15_data = addr_q[15];

endmodule

// File: tb/tb_pmp_csr_file.sv
// Directed bench for pmp_csr_file: hand-computed vectors covering writes, locks,
// illegal accesses, read/write collisions and asynchronous reset.
module tb_pmp_csr_file;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  priv_mode = 2'b11;
    logic        csr_we = 1'b0;
    logic        csr_re = 1'b0;
    logic [11:0] csr_addr = '0;
    logic [31:0] csr_wdata = '0;
    logic [31:0] csr_rdata;
    logic        csr_rvalid, csr_illegal, pmp_changed;
    logic [31:0] cfg_data [4];
    logic [31:0] addr_data [16];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pmp_csr_file dut (
        .clk(clk), .rst_n(rst_n), .priv_mode(priv_mode),
        .csr_we(csr_we), .csr_re(csr_re), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .csr_rvalid(csr_rvalid), .csr_illegal(csr_illegal),
        .pmp_changed(pmp_changed),
        .pmpcfg0_data(cfg_data[0]), .pmpcfg1_data(cfg_data[1]),
        .pmpcfg2_data(cfg_data[2]), .pmpcfg3_data(cfg_data[3]),
        .pmpaddr0_data(addr_data[0]),   .pmpaddr1_data(addr_data[1]),
        .pmpaddr2_data(addr_data[2]),   .pmpaddr3_data(addr_data[3]),
        .pmpaddr4_data(addr_data[4]),   .pmpaddr5_data(addr_data[5]),
        .pmpaddr6_data(addr_data[6]),   .pmpaddr7_data(addr_data[7]),
        .pmpaddr8_data(addr_data[8]),   .pmpaddr9_data(addr_data[9]),
        .pmpaddr10_data(addr_data[10]), .pmpaddr11_data(addr_data[11]),
        .pmpaddr12_data(addr_data[12]), .pmpaddr13_data(addr_data[13]),
        .pmpaddr14_data(addr_data[14]), .pmpaddr15_data(addr_data[15])
    );

    // One request cycle; returns 1 time unit after the capturing edge.
    task automatic drive(input logic we, input logic re, input logic [11:0] a,
                         input logic [31:0] d, input logic [1:0] p);
        @(negedge clk);
        csr_we = we; csr_re = re; csr_addr = a; csr_wdata = d; priv_mode = p;
        @(posedge clk);
        #1;
        csr_we = 1'b0; csr_re = 1'b0; priv_mode = 2'b11;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (cfg_data[0] !== 32'h0) begin errors++; $display("FAIL reset_cfg0 got=%h exp=%h", cfg_data[0], 32'h0); end
        checks++; if (addr_data[15] !== 32'h0) begin errors++; $display("FAIL reset_addr15 got=%h exp=%h", addr_data[15], 32'h0); end
        checks++; if ({csr_rvalid, csr_illegal, pmp_changed} !== 3'b000 || csr_rdata !== 32'h0)
            begin errors++; $display("FAIL reset_status got=%b rdata=%h exp=000 rdata=0", {csr_rvalid, csr_illegal, pmp_changed}, csr_rdata); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_cfg_write();
        drive(1, 0, 12'h3A0, 32'h0000_1F0F, 2'b11);
        checks++; if (cfg_data[0] !== 32'h0000_1F0F) begin errors++; $display("FAIL cfg_write_data got=%h exp=%h", cfg_data[0], 32'h0000_1F0F); end
        checks++; if (pmp_changed !== 1'b1) begin errors++; $display("FAIL cfg_write_changed got=%b exp=1", pmp_changed); end
        drive(0, 1, 12'h3A0, 32'h0, 2'b11);
        checks++; if (csr_rvalid !== 1'b1 || csr_rdata !== 32'h0000_1F0F)
            begin errors++; $display("FAIL cfg_read got=%b/%h exp=1/%h", csr_rvalid, csr_rdata, 32'h0000_1F0F); end
        checks++; if (pmp_changed !== 1'b0) begin errors++; $display("FAIL cfg_read_changed got=%b exp=0", pmp_changed); end
        @(posedge clk); #1;
        checks++; if (csr_rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_pulse got=%b exp=0", csr_rvalid); end
        drive(1, 0, 12'h3A2, 32'h0000_00E6, 2'b11);
        checks++; if (cfg_data[2] !== 32'h0000_0084) begin errors++; $display("FAIL cfg_sanitize got=%h exp=%h", cfg_data[2], 32'h0000_0084); end
    endtask

    task automatic test_cfg_lock();
        drive(1, 0, 12'h3A0, 32'h0000_0082, 2'b11);
        checks++; if (cfg_data[0] !== 32'h0000_0080) begin errors++; $display("FAIL cfg_lock_set got=%h exp=%h", cfg_data[0], 32'h0000_0080); end
        drive(1, 0, 12'h3A0, 32'h0000_00FF, 2'b11);
        checks++; if (cfg_data[0] !== 32'h0000_0080) begin errors++; $display("FAIL cfg_lock_hold got=%h exp=%h", cfg_data[0], 32'h0000_0080); end
        checks++; if (pmp_changed !== 1'b0) begin errors++; $display("FAIL cfg_lock_changed got=%b exp=0", pmp_changed); end
    endtask

    task automatic test_addr_lock();
        drive(1, 0, 12'h3A0, 32'h0000_8800, 2'b11);
        checks++; if (cfg_data[0] !== 32'h0000_8880) begin errors++; $display("FAIL cfg1_tor got=%h exp=%h", cfg_data[0], 32'h0000_8880); end
        drive(1, 0, 12'h3B0, 32'h1234_5678, 2'b11);
        checks++; if (addr_data[0] !== 32'h0 || pmp_changed !== 1'b0)
            begin errors++; $display("FAIL addr0_blocked got=%h/%b exp=0/0", addr_data[0], pmp_changed); end
        drive(1, 0, 12'h3B2, 32'h1234_5678, 2'b11);
        checks++; if (addr_data[2] !== 32'h1234_5678) begin errors++; $display("FAIL addr2_write got=%h exp=%h", addr_data[2], 32'h1234_5678); end
        // entry13 locked TOR with entry12 unlocked: only the TOR rule blocks pmpaddr12
        drive(1, 0, 12'h3A3, 32'h0000_8800, 2'b11);
        drive(1, 0, 12'h3BC, 32'hCAFE_F00D, 2'b11);
        checks++; if (addr_data[12] !== 32'h0) begin errors++; $display("FAIL addr12_tor_blocked got=%h exp=0", addr_data[12]); end
        drive(1, 0, 12'h3BB, 32'hBBBB_0011, 2'b11);
        checks++; if (addr_data[11] !== 32'hBBBB_0011) begin errors++; $display("FAIL addr11_write got=%h exp=%h", addr_data[11], 32'hBBBB_0011); end
        // entry8 locked but A=OFF: pmpaddr7 stays writable
        drive(1, 0, 12'h3B7, 32'h0000_0077, 2'b11);
        checks++; if (addr_data[7] !== 32'h0000_0077) begin errors++; $display("FAIL addr7_write got=%h exp=%h", addr_data[7], 32'h77); end
        drive(1, 0, 12'h3B8, 32'h0000_0088, 2'b11);
        checks++; if (addr_data[8] !== 32'h0) begin errors++; $display("FAIL addr8_own_lock got=%h exp=0", addr_data[8]); end
        drive(1, 0, 12'h3BF, 32'hFFFF_FFFF, 2'b11);
        checks++; if (addr_data[15] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL addr15_write got=%h exp=%h", addr_data[15], 32'hFFFF_FFFF); end
    endtask

    task automatic test_illegal();
        drive(1, 0, 12'h3B3, 32'hDEAD_BEEF, 2'b00);
        checks++; if (csr_illegal !== 1'b1 || csr_rvalid !== 1'b0)
            begin errors++; $display("FAIL illegal_priv got=%b/%b exp=1/0", csr_illegal, csr_rvalid); end
        checks++; if (addr_data[3] !== 32'h0 || pmp_changed !== 1'b0)
            begin errors++; $display("FAIL illegal_priv_state got=%h/%b exp=0/0", addr_data[3], pmp_changed); end
        drive(0, 1, 12'h7C0, 32'h0, 2'b11);
        checks++; if (csr_illegal !== 1'b1 || csr_rvalid !== 1'b0 || csr_rdata !== 32'h0)
            begin errors++; $display("FAIL illegal_addr got=%b/%b/%h exp=1/0/0", csr_illegal, csr_rvalid, csr_rdata); end
        @(posedge clk); #1;
        checks++; if (csr_illegal !== 1'b0) begin errors++; $display("FAIL illegal_pulse got=%b exp=0", csr_illegal); end
    endtask

    task automatic test_back_to_back();
        drive(1, 0, 12'h3B5, 32'h0000_000A, 2'b11);
        drive(1, 1, 12'h3B5, 32'h0000_000B, 2'b11);
        checks++; if (csr_rdata !== 32'h0000_000A || csr_rvalid !== 1'b1)
            begin errors++; $display("FAIL rw_old_value got=%h/%b exp=%h/1", csr_rdata, csr_rvalid, 32'hA); end
        checks++; if (addr_data[5] !== 32'h0000_000B || pmp_changed !== 1'b1)
            begin errors++; $display("FAIL rw_new_value got=%h/%b exp=%h/1", addr_data[5], pmp_changed, 32'hB); end
        drive(1, 0, 12'h3B5, 32'h0000_000B, 2'b11);
        checks++; if (pmp_changed !== 1'b0) begin errors++; $display("FAIL same_value_changed got=%b exp=0", pmp_changed); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        csr_we = 1'b1; csr_re = 1'b1; csr_addr = 12'h3B6; csr_wdata = 32'h6666_6666;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (cfg_data[0] !== 32'h0 || cfg_data[2] !== 32'h0 || addr_data[5] !== 32'h0 || addr_data[15] !== 32'h0)
            begin errors++; $display("FAIL async_reset_data got=%h/%h/%h/%h exp=0", cfg_data[0], cfg_data[2], addr_data[5], addr_data[15]); end
        @(posedge clk); #1;
        csr_we = 1'b0; csr_re = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if ({csr_rvalid, csr_illegal, pmp_changed} !== 3'b000 || addr_data[6] !== 32'h0)
            begin errors++; $display("FAIL reset_discard got=%b/%h exp=000/0", {csr_rvalid, csr_illegal, pmp_changed}, addr_data[6]); end
        drive(1, 0, 12'h3A0, 32'h0000_0001, 2'b11);
        checks++; if (cfg_data[0] !== 32'h0000_0001) begin errors++; $display("FAIL post_reset_write got=%h exp=%h", cfg_data[0], 32'h1); end
    endtask

    initial begin
        test_reset();
        test_cfg_write();
        test_cfg_lock();
        test_addr_lock();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
